// File: rtl/bus_sizing_pkg.sv
// Shared encodings for the 68040 local-bus to buffered-port sizing sequencer:
// FSM states, SIZ and DSACK codes, and the width / byte-count helpers.
package bus_sizing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEG,
        ST_START,
        ST_WAIT,
        ST_ACK,
        ST_TERM,
        ST_ERR
    } state_t;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_WAIT = 2'b11;

    // Port width in bytes for an asserted DSACK code.
    function automatic logic [2:0] dsack_width(input logic [1:0] code);
        case (code)
            DSACK_32: return 3'd4;
            DSACK_16: return 3'd2;
            DSACK_8:  return 3'd1;
            default:  return 3'd4;
        endcase
    endfunction

    // Line requests are serviced as plain longs.
    function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
        case (siz)
            SIZ_BYTE: return 3'd1;
            SIZ_WORD: return 3'd2;
            SIZ_LONG: return 3'd4;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] psiz_encode(input logic [2:0] remaining);
        return (remaining == 3'd4) ? 2'b00 : remaining[1:0];
    endfunction

endpackage

// File: rtl/bus_sizing_sequencer_step.sv
// One port-cycle sizing step: how many bytes the port takes this cycle,
// which CPU byte lanes they occupy, and where the transfer resumes.
module sizing_step
    import bus_sizing_pkg::*;
(
    input  logic [1:0] pa,
    input  logic [2:0] remaining,
    input  logic [2:0] width,
    output logic [2:0] xfer,
    output logic [3:0] mask,
    output logic [1:0] next_pa,
    output logic [2:0] next_remaining
);

    logic [2:0] offset;
    logic [2:0] room;
    logic [1:0] lane;

    always_comb begin
        case (width)
            3'd4:    offset = {1'b0, pa};
            3'd2:    offset = {2'b00, pa[0]};
            default: offset = 3'd0;
        endcase
        room = width - offset;
        xfer = (remaining < room) ? remaining : room;

        // Byte offset 0 sits on D31:24, which is mask bit 3.
        mask = 4'b0000;
        lane = 2'b00;
        for (int i = 0; i < 4; i++) begin
            lane = pa + 2'(i);
            if (3'(i) < xfer) begin
                mask[~lane] = 1'b1;
            end
        end

        next_pa        = pa + xfer[1:0];
        next_remaining = remaining - xfer;
    end

endmodule

// File: rtl/bus_sizing_sequencer.sv
// Splits one 68040 transfer into DSACK-sized port cycles on the buffered bus
// and terminates the CPU cycle with nTA / nTBI, or nTEA on port timeout.
module bus_sizing_sequencer
    import bus_sizing_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       CLK40,
    input  logic       RESET,
    input  logic       nTS_CPU,
    input  logic       nBG,
    input  logic       RnW,
    input  logic [1:0] SIZ,
    input  logic [1:0] A,
    input  logic [1:0] DSACK,
    output logic       nTS,
    output logic [1:0] PA,
    output logic [1:0] PSIZ,
    output logic       PRNW,
    output logic       DRIVE,
    output logic [3:0] LATCH,
    output logic [1:0] PORT_W,
    output logic       nTA,
    output logic       nTBI,
    output logic       nTEA,
    output logic       BUSY
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] remaining;
    logic [1:0] siz_q;
    logic [7:0] wait_count;

    logic       start_req;
    logic       dsack_idle;
    logic       rnw_eff;
    logic [2:0] step_width;
    logic [2:0] step_xfer;
    logic [3:0] step_mask;
    logic [1:0] step_pa;
    logic [2:0] step_remaining;

    logic       nts_d;
    logic       drive_d;
    logic [3:0] latch_d;
    logic       nta_d;
    logic       ntbi_d;
    logic       ntea_d;
    logic       busy_d;

    assign start_req  = (state == ST_IDLE) && !nTS_CPU && !nBG;
    assign dsack_idle = (DSACK == DSACK_WAIT);
    assign PSIZ       = psiz_encode(remaining);

    // In WAIT the step sees the live acknowledge so LATCH is ready on the ACK edge.
    assign step_width = (state == ST_WAIT) ? dsack_width(DSACK) : dsack_width(PORT_W);

    sizing_step u_step (
        .pa            (PA),
        .remaining     (remaining),
        .width         (step_width),
        .xfer          (step_xfer),
        .mask          (step_mask),
        .next_pa       (step_pa),
        .next_remaining(step_remaining)
    );

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_req) next_state = dsack_idle ? ST_START : ST_NEG;
            ST_NEG:   if (dsack_idle) next_state = ST_START;
            ST_START: next_state = ST_WAIT;
            ST_WAIT: begin
                if (!dsack_idle) begin
                    next_state = ST_ACK;
                end else if (wait_count == TIMEOUT_LAST) begin
                    next_state = ST_ERR;
                end
            end
            ST_ACK:   next_state = (step_xfer == remaining) ? ST_TERM : ST_NEG;
            ST_TERM:  next_state = ST_IDLE;
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Every output is registered, so it is derived here from the state being entered.
    always_comb begin
        rnw_eff = (state == ST_IDLE) ? RnW : PRNW;
        nts_d   = (next_state != ST_START);
        drive_d = !rnw_eff && ((next_state == ST_START) || (next_state == ST_WAIT) ||
                               (next_state == ST_ACK));
        latch_d = ((state == ST_WAIT) && (next_state == ST_ACK) && PRNW) ? step_mask : 4'b0000;
        nta_d   = (next_state != ST_TERM);
        ntbi_d  = !((next_state == ST_TERM) && (siz_q == SIZ_LINE));
        ntea_d  = (next_state != ST_ERR);
        busy_d  = (next_state != ST_IDLE);
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            PA         <= 2'b00;
            remaining  <= 3'd0;
            siz_q      <= SIZ_LONG;
            PRNW       <= 1'b1;
            PORT_W     <= 2'b00;
            wait_count <= 8'd0;
            nTS        <= 1'b1;
            DRIVE      <= 1'b0;
            LATCH      <= 4'b0000;
            nTA        <= 1'b1;
            nTBI       <= 1'b1;
            nTEA       <= 1'b1;
            BUSY       <= 1'b0;
        end else begin
            if (start_req) begin
                PA        <= A;
                remaining <= siz_bytes(SIZ);
                siz_q     <= SIZ;
                PRNW      <= RnW;
            end
            if (state == ST_ACK) begin
                PA        <= step_pa;
                remaining <= step_remaining;
            end
            if (state == ST_START) begin
                wait_count <= 8'd0;
            end else if ((state == ST_WAIT) && dsack_idle) begin
                wait_count <= wait_count + 8'd1;
            end
            if ((state == ST_WAIT) && !dsack_idle) begin
                PORT_W <= DSACK;
            end
            nTS   <= nts_d;
            DRIVE <= drive_d;
            LATCH <= latch_d;
            nTA   <= nta_d;
            nTBI  <= ntbi_d;
            nTEA  <= ntea_d;
            BUSY  <= busy_d;
        end
    end

endmodule

// File: tb/tb_bus_sizing_sequencer.sv
// Directed bench for bus_sizing_sequencer: a transaction-level model builds the
// per-edge stimulus and expected outputs, and one process compares every edge.
`timescale 1ns/1ps
module tb_bus_sizing_sequencer;

    localparam int TO = 4;
    localparam int N  = 114;

    logic       CLK40 = 1'b0;
    logic       RESET;
    logic       nTS_CPU;
    logic       nBG;
    logic       RnW;
    logic [1:0] SIZ;
    logic [1:0] A;
    logic [1:0] DSACK;
    logic       nTS;
    logic [1:0] PA;
    logic [1:0] PSIZ;
    logic       PRNW;
    logic       DRIVE;
    logic [3:0] LATCH;
    logic [1:0] PORT_W;
    logic       nTA;
    logic       nTBI;
    logic       nTEA;
    logic       BUSY;

    // Stimulus sampled at edge t, and outputs expected just after edge t.
    logic       rst_s [N];
    logic       ntscpu_s [N];
    logic       nbg_s [N];
    logic       rnw_s [N];
    logic [1:0] siz_s [N];
    logic [1:0] a_s [N];
    logic [1:0] dsack_s [N];

    logic       e_nts [N];
    logic [1:0] e_pa [N];
    logic [1:0] e_psiz [N];
    logic       e_prnw [N];
    logic       e_drive [N];
    logic [3:0] e_latch [N];
    logic [1:0] e_portw [N];
    logic       e_nta [N];
    logic       e_ntbi [N];
    logic       e_ntea [N];
    logic       e_busy [N];

    int   n_vec  = 0;
    int   n_miss = 0;
    int   cur_edge = 0;
    logic cmp_on = 1'b0;

    bus_sizing_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK40  (CLK40),
        .RESET  (RESET),
        .nTS_CPU(nTS_CPU),
        .nBG    (nBG),
        .RnW    (RnW),
        .SIZ    (SIZ),
        .A      (A),
        .DSACK  (DSACK),
        .nTS    (nTS),
        .PA     (PA),
        .PSIZ   (PSIZ),
        .PRNW   (PRNW),
        .DRIVE  (DRIVE),
        .LATCH  (LATCH),
        .PORT_W (PORT_W),
        .nTA    (nTA),
        .nTBI   (nTBI),
        .nTEA   (nTEA),
        .BUSY   (BUSY)
    );

    always #12.5 CLK40 = ~CLK40;

    task automatic set_defaults();
        for (int i = 0; i < N; i++) begin
            rst_s[i] = 1'b0;  ntscpu_s[i] = 1'b1; nbg_s[i] = 1'b0; rnw_s[i] = 1'b1;
            siz_s[i] = 2'b00; a_s[i] = 2'b00;     dsack_s[i] = 2'b11;
            e_nts[i] = 1'b1;  e_pa[i] = 2'b00;    e_psiz[i] = 2'b00; e_prnw[i] = 1'b1;
            e_drive[i] = 1'b0; e_latch[i] = 4'b0000; e_portw[i] = 2'b00;
            e_nta[i] = 1'b1;  e_ntbi[i] = 1'b1;   e_ntea[i] = 1'b1;  e_busy[i] = 1'b0;
        end
    endtask

    task automatic hold_pa(input int t, input int pa, input int rem);
        for (int i = t; i < N; i++) begin
            e_pa[i]   = 2'(pa);
            e_psiz[i] = 2'(rem % 4);
        end
    endtask

    task automatic hold_prnw(input int t, input logic v);
        for (int i = t; i < N; i++) e_prnw[i] = v;
    endtask

    task automatic hold_portw(input int t, input logic [1:0] v);
        for (int i = t; i < N; i++) e_portw[i] = v;
    endtask

    task automatic mark(input int from, input int upto, input logic busy, input logic drive);
        for (int i = from; i <= upto; i++) begin
            if (busy)  e_busy[i]  = 1'b1;
            if (drive) e_drive[i] = 1'b1;
        end
    endtask

    task automatic start_xfer(input int n, input logic r, input logic [1:0] s, input logic [1:0] a,
                              output int rem);
        ntscpu_s[n] = 1'b0;
        rnw_s[n]    = r;
        siz_s[n]    = s;
        a_s[n]      = a;
        rem = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
        hold_prnw(n, r);
        hold_pa(n, int'(a), rem);
    endtask

    // Full transfer: bytes per cycle = min(remaining, width - PA mod width).
    task automatic model_xfer(input int n, input logic r, input logic [1:0] s, input logic [1:0] a,
                              input logic [1:0] code, input int neg_hold, input int w0, input int wn);
        int rem, pa, width, x, mask, t, ack, k, last;
        start_xfer(n, r, s, a, rem);
        pa    = int'(a);
        width = (code == 2'b00) ? 4 : (code == 2'b01) ? 2 : 1;
        for (int i = 0; i < neg_hold; i++) dsack_s[n + i] = code;
        t = n + neg_hold;
        k = 0;
        last = n;
        while (rem > 0) begin
            e_nts[t] = 1'b0;
            ack = t + 2 + ((k == 0) ? w0 : wn);
            dsack_s[ack] = code;
            x = width - (pa % width);
            if (rem < x) x = rem;
            mask = 0;
            for (int i = 0; i < x; i++) mask = mask | (1 << (3 - ((pa + i) % 4)));
            if (!r) mark(t, ack, 1'b0, 1'b1);
            if (r) e_latch[ack] = 4'(mask);
            hold_portw(ack, code);
            pa  = (pa + x) % 4;
            rem = rem - x;
            hold_pa(ack + 1, pa, rem);
            if (rem == 0) begin
                last = ack + 1;
                e_nta[last] = 1'b0;
                if (s == 2'b11) e_ntbi[last] = 1'b0;
            end else begin
                t = ack + 2;
            end
            k++;
        end
        mark(n, last, 1'b1, 1'b0);
    endtask

    task automatic model_timeout(input int n, input logic r, input logic [1:0] s, input logic [1:0] a);
        int rem, err;
        start_xfer(n, r, s, a, rem);
        e_nts[n] = 1'b0;
        err = n + 1 + TO;
        e_ntea[err] = 1'b0;
        mark(n, err, 1'b1, 1'b0);
        if (!r) mark(n, err - 1, 1'b0, 1'b1);
    endtask

    task automatic model_reset(input int n, input logic r, input logic [1:0] s, input logic [1:0] a,
                               input int rst_at);
        int rem;
        start_xfer(n, r, s, a, rem);
        e_nts[n] = 1'b0;
        mark(n, rst_at - 1, 1'b1, !r);
        rst_s[rst_at] = 1'b1;
        hold_pa(rst_at, 0, 0);
        hold_prnw(rst_at, 1'b1);
        hold_portw(rst_at, 2'b00);
    endtask

    task automatic build_model();
        set_defaults();
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        model_xfer(4,  1'b1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        model_xfer(10, 1'b0, 2'b00, 2'b00, 2'b01, 0, 0, 0);
        model_xfer(20, 1'b1, 2'b01, 2'b11, 2'b00, 0, 0, 0);
        model_xfer(26, 1'b1, 2'b10, 2'b10, 2'b10, 0, 0, 0);
        model_xfer(36, 1'b1, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        model_timeout(42, 1'b1, 2'b00, 2'b00);
        model_reset(50, 1'b0, 2'b00, 2'b00, 53);
        model_xfer(56, 1'b1, 2'b00, 2'b01, 2'b00, 0, TO - 1, 1);
        model_xfer(70, 1'b0, 2'b10, 2'b01, 2'b01, 0, 1, 0);
        ntscpu_s[72] = 1'b0; siz_s[72] = 2'b01; a_s[72] = 2'b11; rnw_s[72] = 1'b1;
        ntscpu_s[82] = 1'b0; nbg_s[82] = 1'b1;
        model_xfer(86, 1'b0, 2'b00, 2'b00, 2'b10, 0, 0, 0);
        model_xfer(104, 1'b1, 2'b00, 2'b00, 2'b00, 2, 0, 0);
    endtask

    task automatic applyStimulus(input int t);
        RESET   = rst_s[t];
        nTS_CPU = ntscpu_s[t];
        nBG     = nbg_s[t];
        RnW     = rnw_s[t];
        SIZ     = siz_s[t];
        A       = a_s[t];
        DSACK   = dsack_s[t];
    endtask

    task automatic check_sig(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    // Hand-worked values that tie the model to the written timing rules.
    task automatic pin_check(input int idx);
        case (idx)
            6:   check_sig("pin_latch_long", idx, LATCH, 4'b1111);
            7:   check_sig("pin_nta_long", idx, {3'b0, nTA}, 4'b0000);
            14: begin
                check_sig("pin_pa_second", idx, {2'b0, PA}, 4'b0010);
                check_sig("pin_psiz_second", idx, {2'b0, PSIZ}, 4'b0010);
            end
            22:  check_sig("pin_latch_byte", idx, LATCH, 4'b0001);
            28:  check_sig("pin_latch_word_a", idx, LATCH, 4'b0010);
            32:  check_sig("pin_latch_word_b", idx, LATCH, 4'b0001);
            39: begin
                check_sig("pin_nta_line", idx, {3'b0, nTA}, 4'b0000);
                check_sig("pin_ntbi_line", idx, {3'b0, nTBI}, 4'b0000);
            end
            47:  check_sig("pin_ntea", idx, {3'b0, nTEA}, 4'b0000);
            48:  check_sig("pin_busy_after_err", idx, {3'b0, BUSY}, 4'b0000);
            53: begin
                check_sig("pin_reset_busy", idx, {3'b0, BUSY}, 4'b0000);
                check_sig("pin_reset_drive", idx, {3'b0, DRIVE}, 4'b0000);
            end
            61:  check_sig("pin_latch_misaligned", idx, LATCH, 4'b0111);
            101: check_sig("pin_nta_byte_port", idx, {3'b0, nTA}, 4'b0000);
            default: ;
        endcase
    endtask

    task automatic checkOutput(input int idx);
        check_sig("nTS",    idx, {3'b0, nTS},    {3'b0, e_nts[idx]});
        check_sig("PA",     idx, {2'b0, PA},     {2'b0, e_pa[idx]});
        check_sig("PSIZ",   idx, {2'b0, PSIZ},   {2'b0, e_psiz[idx]});
        check_sig("PRNW",   idx, {3'b0, PRNW},   {3'b0, e_prnw[idx]});
        check_sig("DRIVE",  idx, {3'b0, DRIVE},  {3'b0, e_drive[idx]});
        check_sig("LATCH",  idx, LATCH,          e_latch[idx]);
        check_sig("PORT_W", idx, {2'b0, PORT_W}, {2'b0, e_portw[idx]});
        check_sig("nTA",    idx, {3'b0, nTA},    {3'b0, e_nta[idx]});
        check_sig("nTBI",   idx, {3'b0, nTBI},   {3'b0, e_ntbi[idx]});
        check_sig("nTEA",   idx, {3'b0, nTEA},   {3'b0, e_ntea[idx]});
        check_sig("BUSY",   idx, {3'b0, BUSY},   {3'b0, e_busy[idx]});
        pin_check(idx);
    endtask

    always @(negedge CLK40) begin
        if (cmp_on) checkOutput(cur_edge);
    end

    initial begin
        build_model();
        for (int t = 0; t < N; t++) begin
            applyStimulus(t);
            @(posedge CLK40);
            cur_edge = t;
            cmp_on   = 1'b1;
            @(negedge CLK40);
        end
        #1;
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
